// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller:
// opcode constants, FSM state type and default widths.
package alu_pkg;

    localparam int WIDTH_D = 32;
    localparam int OPW_D   = 5;

    localparam logic [OPW_D-1:0] OP_NOP = 5'd0;
    localparam logic [OPW_D-1:0] OP_ADD = 5'd1;
    localparam logic [OPW_D-1:0] OP_SUB = 5'd2;
    localparam logic [OPW_D-1:0] OP_AND = 5'd4;
    localparam logic [OPW_D-1:0] OP_OR  = 5'd5;
    localparam logic [OPW_D-1:0] OP_SLT = 5'd6;
    localparam logic [OPW_D-1:0] OP_SGE = 5'd7;
    localparam logic [OPW_D-1:0] OP_XOR = 5'd9;
    localparam logic [OPW_D-1:0] OP_EQ  = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a single requester always wins,
// on a tie the port that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_any,
    output logic       o_idx
);

    always_comb begin
        o_any = |i_valid;
        o_idx = 1'b0;
        unique case (i_valid)
            2'b01:   o_idx = 1'b0;
            2'b10:   o_idx = 1'b1;
            2'b11:   o_idx = ~i_last;
            default: o_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared ALU and returns
// the captured result through a valid/ready response handshake.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int               WIDTH  = WIDTH_D,
    parameter int               OPW    = OPW_D,
    parameter logic [OPW-1:0]   NOP_OP = '0
) (
    input  logic             CLK,
    input  logic             RSTa,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,

    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zero,

    output logic [OPW-1:0]   ALU_operation,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] res,
    input  logic             zero,

    output logic             busy,
    output logic             grant
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_grant;
    logic [OPW-1:0]     r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_zero;

    logic               w_any;
    logic               w_idx;
    logic               w_take;
    logic               w_ack;

    rr_arb2 u_arb (
        .i_valid ({r1_valid, r0_valid}),
        .i_last  (r_last),
        .o_any   (w_any),
        .o_idx   (w_idx)
    );

    assign w_ack = r_grant ? r1_rsp_ready : r0_rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = EXEC;
                    r0_ready    = ~w_idx;
                    r1_ready    = w_idx;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (w_ack)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_grant <= w_idx;
                r_op    <= w_idx ? r1_op : r0_op;
                r_a     <= w_idx ? r1_a  : r0_a;
                r_b     <= w_idx ? r1_b  : r0_b;
            end
            if (r_state == EXEC) begin
                r_res  <= res;
                r_zero <= zero;
            end
            if (r_state == RESP && w_ack)
                r_last <= r_grant;
        end
    end

    // Opcode is only live during EXEC; operands simply hold to avoid toggling.
    assign ALU_operation = (r_state == EXEC) ? r_op : NOP_OP;
    assign A             = r_a;
    assign B             = r_b;

    assign r0_rsp_valid  = (r_state == RESP) && !r_grant;
    assign r1_rsp_valid  = (r_state == RESP) && r_grant;
    assign rsp_res       = r_res;
    assign rsp_zero      = r_zero;
    assign busy          = (r_state != IDLE);
    assign grant         = r_grant;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU plus a transaction-level
// reference model checked every cycle, and directed literal checks.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTa;
    logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [4:0]  r0_op, r1_op, ALU_operation;
    logic [31:0] r0_a, r0_b, r1_a, r1_b, A, B, res, rsp_res;
    logic        zero, rsp_zero, busy, grant;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    alu_share_ctrl dut (
        .CLK(CLK), .RSTa(RSTa),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero),
        .ALU_operation(ALU_operation), .A(A), .B(B),
        .res(res), .zero(zero), .busy(busy), .grant(grant)
    );

    // Behavioural ALU; EQ compares by subtraction so equal operands give zero=1.
    function automatic logic [31:0] alu_f(logic [4:0] op, logic [31:0] a,
                                          logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SGE:  return {31'd0, $signed(a) >= $signed(b)};
            OP_XOR:  return a ^ b;
            OP_EQ:   return a - b;
            default: return 32'd0;
        endcase
    endfunction

    assign res  = alu_f(ALU_operation, A, B);
    assign zero = (res == 32'd0);

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding job, tracked by owner and age in cycles.
    int          m_own;
    int          m_age;
    int          m_last;
    logic        m_ok = 1'b0;
    logic        m_gidx;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    logic        m_zero;

    function automatic int winner();
        if (r0_valid && r1_valid) return 1 - m_last;
        if (r0_valid) return 0;
        if (r1_valid) return 1;
        return -1;
    endfunction

    always @(posedge CLK) begin
        if (RSTa) begin
            m_ok = 1'b1; m_own = -1; m_age = 0; m_last = 1; m_gidx = 1'b0;
            m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_zero = 1'b0;
        end else if (m_ok) begin
            if (m_own < 0) begin
                int w;
                w = winner();
                if (w >= 0) begin
                    m_own = w; m_age = 0; m_gidx = (w == 1);
                    m_op = w ? r1_op : r0_op;
                    m_a  = w ? r1_a  : r0_a;
                    m_b  = w ? r1_b  : r0_b;
                end
            end else if (m_age == 0) begin
                m_res  = alu_f(m_op, m_a, m_b);
                m_zero = (m_res == 32'd0);
                m_age  = 1;
            end else if ((m_own == 0 && r0_rsp_ready) ||
                         (m_own == 1 && r1_rsp_ready)) begin
                m_last = m_own;
                m_own  = -1;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_ok) begin
            int w;
            logic idle;
            idle = (m_own < 0);
            w = idle ? winner() : -1;
            chk("m_r0_ready", r0_ready, w == 0);
            chk("m_r1_ready", r1_ready, w == 1);
            chk("m_busy", busy, !idle);
            chk("m_grant", grant, m_gidx);
            chk("m_aluop", ALU_operation,
                (!idle && m_age == 0) ? m_op : OP_NOP);
            chk("m_A", A, m_a);
            chk("m_B", B, m_b);
            chk("m_r0_rspv", r0_rsp_valid, !idle && m_age == 1 && m_own == 0);
            chk("m_r1_rspv", r1_rsp_valid, !idle && m_age == 1 && m_own == 1);
            chk("m_res", rsp_res, m_res);
            chk("m_zero", rsp_zero, m_zero);
        end
    end

    // Logs of handshakes and consumed responses for directed checks.
    int        hs_q[$];
    int        rp_q[$];
    logic [31:0] rr_q[$];
    int        rspv_cnt = 0;

    always @(negedge CLK) begin
        if (r0_valid && r0_ready) hs_q.push_back(0);
        if (r1_valid && r1_ready) hs_q.push_back(1);
        if (r0_rsp_valid || r1_rsp_valid) rspv_cnt++;
        if (r0_rsp_valid && r0_rsp_ready) begin
            rp_q.push_back(0); rr_q.push_back(rsp_res);
        end
        if (r1_rsp_valid && r1_rsp_ready) begin
            rp_q.push_back(1); rr_q.push_back(rsp_res);
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTa = 1'b1;
        r0_valid = 0; r1_valid = 0;
        r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_op = '0; r1_op = '0;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        step(2);
        RSTa = 1'b0;
        hs_q.delete(); rp_q.delete(); rr_q.delete();
    endtask

    initial begin
        do_reset();
        neg();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_res", rsp_res, 0);
        chk("rst_aluop", ALU_operation, OP_NOP);
        step();

        // Single op with latency
        r0_valid = 1; r0_op = OP_ADD; r0_a = 5; r0_b = 7; r0_rsp_ready = 1;
        neg();
        chk("t1_ready", r0_ready, 1);
        chk("t1_busy0", busy, 0);
        step();
        r0_valid = 0;
        neg();
        chk("t1_aluop", ALU_operation, OP_ADD);
        chk("t1_busy1", busy, 1);
        step();
        neg();
        chk("t1_rspv", r0_rsp_valid, 1);
        chk("t1_res", rsp_res, 12);
        chk("t1_zero", rsp_zero, 0);
        chk("t1_busy2", busy, 1);
        step();
        neg();
        chk("t1_busy3", busy, 0);

        // Tie fairness
        do_reset();
        r0_valid = 1; r0_op = OP_SUB; r0_a = 10; r0_b = 3;
        r1_valid = 1; r1_op = OP_XOR; r1_a = 32'hF0; r1_b = 32'hFF;
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        step(12);
        r0_valid = 0; r1_valid = 0;
        step(2);
        chk("t2_hs_cnt", hs_q.size(), 4);
        if (hs_q.size() >= 4) begin
            chk("t2_g0", hs_q[0], 0);
            chk("t2_g1", hs_q[1], 1);
            chk("t2_g2", hs_q[2], 0);
            chk("t2_g3", hs_q[3], 1);
        end
        chk("t2_rp_cnt", rp_q.size(), 4);
        if (rp_q.size() >= 2) begin
            chk("t2_p0", rp_q[0], 0);
            chk("t2_r0", rr_q[0], 7);
            chk("t2_p1", rp_q[1], 1);
            chk("t2_r1", rr_q[1], 32'h0F);
        end

        // Back-pressure
        do_reset();
        r1_valid = 1; r1_op = OP_EQ; r1_a = 32'h1234; r1_b = 32'h1234;
        neg();
        chk("t3_r1_ready", r1_ready, 1);
        step();
        r1_valid = 0;
        r0_valid = 1; r0_op = OP_ADD; r0_a = 2; r0_b = 3; r0_rsp_ready = 1;
        neg();
        chk("t3_r0_blk_exec", r0_ready, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("t3_rspv", r1_rsp_valid, 1);
            chk("t3_zero", rsp_zero, 1);
            chk("t3_res", rsp_res, 0);
            chk("t3_r0_blk", r0_ready, 0);
            step();
        end
        r1_rsp_ready = 1;
        neg();
        chk("t3_rspv_last", r1_rsp_valid, 1);
        step();
        neg();
        chk("t3_r0_win", r0_ready, 1);
        step();
        r0_valid = 0;
        step(3);

        // Reset mid-op
        do_reset();
        r0_valid = 1; r0_op = OP_AND; r0_a = 32'hFF; r0_b = 32'h0F;
        r0_rsp_ready = 1;
        step();
        r0_valid = 0;
        RSTa = 1;
        neg();
        chk("t4_in_exec", ALU_operation, OP_AND);
        rspv_cnt = 0;
        step();
        RSTa = 0;
        neg();
        chk("t4_busy", busy, 0);
        chk("t4_aluop", ALU_operation, OP_NOP);
        chk("t4_A", A, 0);
        chk("t4_B", B, 0);
        chk("t4_res", rsp_res, 0);
        chk("t4_grant", grant, 0);
        step(5);
        chk("t4_no_rsp", rspv_cnt, 0);

        // Wrap values
        r0_valid = 1; r0_op = OP_ADD; r0_a = 32'hFFFF_FFFF; r0_b = 1;
        r0_rsp_ready = 1;
        step();
        r0_valid = 0;
        step();
        neg();
        chk("t6_rspv", r0_rsp_valid, 1);
        chk("t6_res", rsp_res, 0);
        chk("t6_zero", rsp_zero, 1);
        step();

        // Idle quiet
        for (int i = 0; i < 10; i++) begin
            neg();
            chk("t5_aluop", ALU_operation, OP_NOP);
            chk("t5_A", A, 32'hFFFF_FFFF);
            chk("t5_B", B, 1);
            chk("t5_busy", busy, 0);
            chk("t5_quiet", {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid}, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
